// File: rtl/alucont_seq.sv
// -----------------------------------------------------------------------------
// alucont_seq
//
// Registered, handshaked ALU control decoder for the multi-cycle datapath.
// On an accepted start it decodes {aluop, funct} into a 4-bit ALU control word
// and holds it on gout until the next accepted start. Single-cycle encodings
// complete with a one-cycle done pulse right after the start edge.
//
// Optional feature, selected by the macro ALUCONT_MULT_EN:
//   defined   : R-type funct 1000 (aluop1=0) launches an iterative WIDTH-bit
//               unsigned shift-add multiply (MUL state, WIDTH cycles).
//   undefined : that encoding decodes to NOOP_CODE as a single-cycle op;
//               busy and result are tied to 0.
//
// Parameters:
//   WIDTH      multiplier operand/result width (>= 2)
//   NOOP_CODE  control word emitted for no-op/undefined encodings
//
// Ports:
//   clk     in   rising-edge clock
//   reset   in   asynchronous, active-high reset
//   start   in   operation request, sampled only in IDLE
//   aluop   in   [2:0] {aluop2, aluop1, aluop0}
//   funct   in   [3:0] {f3, f2, f1, f0}
//   opa     in   [WIDTH-1:0] multiplicand, sampled with start
//   opb     in   [WIDTH-1:0] multiplier, sampled with start
//   gout    out  [3:0] registered ALU control word
//   result  out  [WIDTH-1:0] product, low WIDTH bits
//   busy    out  high while a multiply iterates
//   done    out  one-cycle completion pulse
// -----------------------------------------------------------------------------
module alucont_seq #(
  parameter int         WIDTH     = 32,
  parameter logic [3:0] NOOP_CODE = 4'b1111
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       aluop,
  input  logic [3:0]       funct,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic [3:0]       gout,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             done
);

  // Decoder output: mul marks the encoding that launches the multiplier.
  typedef struct packed {
    logic       mul;
    logic [3:0] word;
  } dec_t;

  // First-match priority decode. Every path assigns a word, so no encoding
  // can leave a stale control value behind.
  function automatic dec_t decode(input logic [2:0] op, input logic [3:0] fn);
    dec_t d;
    d.mul  = 1'b0;
    d.word = NOOP_CODE;
    if (op == 3'b000) begin
      d.word = 4'b0010;
    end else if (op == 3'b001) begin
      d.word = 4'b0110;
    end else if (op == 3'b011) begin
      d.word = 4'b1100;
    end else if (op == 3'b010) begin
      d.word = NOOP_CODE;
    end else begin
      // aluop2 = 1: R-type, funct selects the operation
      if (fn == 4'b0000) begin
        d.word = 4'b0010;
      end else if (!op[1] && fn[3] && fn[1]) begin
        d.word = 4'b0111;
      end else if (!op[1] && fn == 4'b0010) begin
        d.word = 4'b0110;
      end else if (fn == 4'b0101) begin
        d.word = 4'b0001;
      end else if (fn == 4'b0100) begin
        d.word = 4'b0000;
      end else if (fn == 4'b0111) begin
        d.word = 4'b1001;
      end else if (fn == 4'b0110) begin
        d.word = 4'b1101;
      end else if (fn == 4'b0011) begin
        d.word = 4'b1101;
      end else if (!op[1] && fn == 4'b1000) begin
`ifdef ALUCONT_MULT_EN
        // The multiplier reuses the adder, so gout shows ADD while it runs.
        d.mul  = 1'b1;
        d.word = 4'b0010;
`else
        d.word = NOOP_CODE;
`endif
      end else if (op[1] && !op[0] && fn[3]) begin
        d.word = 4'b0100;
      end else begin
        d.word = NOOP_CODE;
      end
    end
    return d;
  endfunction

  dec_t dec;

`ifdef ALUCONT_MULT_EN

  // ---------------------------------------------------------------------------
  // Multiply-capable build: IDLE/MUL sequencer
  // ---------------------------------------------------------------------------
  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_t;

  // Counter wide enough to hold WIDTH itself after the final increment.
  localparam int             CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_t           state_reg,  state_next;
  logic [3:0]       gout_reg,   gout_next;
  logic [WIDTH-1:0] a_reg,      a_next;
  logic [WIDTH-1:0] b_reg,      b_next;
  logic [WIDTH-1:0] acc_reg,    acc_next;
  logic [CW-1:0]    count_reg,  count_next;
  logic [WIDTH-1:0] result_reg, result_next;
  logic             busy_reg,   busy_next;
  logic             done_reg,   done_next;
  logic [WIDTH-1:0] acc_sum;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= IDLE;
      gout_reg   <= NOOP_CODE;
      a_reg      <= '0;
      b_reg      <= '0;
      acc_reg    <= '0;
      count_reg  <= '0;
      result_reg <= '0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      gout_reg   <= gout_next;
      a_reg      <= a_next;
      b_reg      <= b_next;
      acc_reg    <= acc_next;
      count_reg  <= count_next;
      result_reg <= result_next;
      busy_reg   <= busy_next;
      done_reg   <= done_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    gout_next   = gout_reg;
    a_next      = a_reg;
    b_next      = b_reg;
    acc_next    = acc_reg;
    count_next  = count_reg;
    result_next = result_reg;
    busy_next   = busy_reg;
    done_next   = 1'b0;
    dec         = decode(aluop, funct);
    // Partial-product accumulate; carries beyond WIDTH bits fall off.
    acc_sum     = acc_reg + (b_reg[0] ? a_reg : '0);

    case (state_reg)
      IDLE: begin
        if (start) begin
          gout_next = dec.word;
          if (dec.mul) begin
            a_next     = opa;
            b_next     = opb;
            acc_next   = '0;
            count_next = '0;
            busy_next  = 1'b1;
            state_next = MUL;
          end else begin
            done_next = 1'b1;
          end
        end
      end

      MUL: begin
        // start is ignored here; operands in flight stay untouched.
        acc_next   = acc_sum;
        a_next     = a_reg << 1;
        b_next     = b_reg >> 1;
        count_next = count_reg + 1'b1;
        if (count_reg == LAST) begin
          // Final iteration: publish the sum formed this cycle directly.
          result_next = acc_sum;
          busy_next   = 1'b0;
          done_next   = 1'b1;
          state_next  = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign gout   = gout_reg;
  assign result = result_reg;
  assign busy   = busy_reg;
  assign done   = done_reg;

`else

  // ---------------------------------------------------------------------------
  // Decode-only build: every accepted start completes in one cycle
  // ---------------------------------------------------------------------------
  logic [3:0] gout_reg, gout_next;
  logic       done_reg, done_next;
  logic       unused_ok;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gout_reg <= NOOP_CODE;
      done_reg <= 1'b0;
    end else begin
      gout_reg <= gout_next;
      done_reg <= done_next;
    end
  end

  always_comb begin
    gout_next = gout_reg;
    done_next = 1'b0;
    dec       = decode(aluop, funct);
    if (start) begin
      gout_next = dec.word;
      done_next = 1'b1;
    end
  end

  // Operands only matter to the multiplier, which is not built here.
  assign unused_ok = ^{opa, opb, dec.mul};

  assign gout   = gout_reg;
  assign result = '0;
  assign busy   = 1'b0;
  assign done   = done_reg;

`endif

endmodule

// File: doc/alucont_seq.md
# alucont_seq

Registered, handshaked successor to the combinational ALU control decoder, for the multi-cycle datapath. It decodes `aluop`/`funct` into the 4-bit ALU control word and holds that word in a register. It adds an iterative WIDTH-bit shift-add multiply sequencer for R-type funct 1000. The controller issues `start`, uses `gout` to drive the ALU, and waits for `done` before the next operation.

## Interface
- WIDTH, 32, multiplier operand/result width (≥2)
- NOOP_CODE, 4'b1111, control word emitted for no-op/undefined encodings
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- aluop  in  3  {aluop2,aluop1,aluop0}
- funct  in  4  {f3,f2,f1,f0}
- opa  in  WIDTH  multiplicand, sampled with start
- opb  in  WIDTH  multiplier, sampled with start
- gout  out  4  registered ALU control word
- result  out  WIDTH  product, low WIDTH bits
- busy  out  1  high while a multiply iterates
- done  out  1  one-cycle completion pulse

## Operation
- States: IDLE, MUL. Reset → IDLE.
- Decode uses first-match priority, evaluated on the inputs sampled at start:
  - aluop 000 → 0010.
  - aluop 001 → 0110.
  - aluop 011 → 1100.
  - aluop 010 → NOOP_CODE.
  - aluop2=1 (R-type):
    - funct 0000 → 0010.
    - aluop1=0 & f3 & f1 → 0111.
    - aluop1=0 & funct 0010 → 0110.
    - 0101 → 0001.
    - 0100 → 0000.
    - 0111 → 1001.
    - 0110 → 1101.
    - 0011 → 1101.
    - funct 1000 with aluop1=0 → multiply (when enabled).
    - aluop1 & ~aluop0 & f3 → 0100.
    - aluop1 & aluop0 & ~f3 → NOOP_CODE.
    - anything else → NOOP_CODE.
  - No encoding retains a stale value.
- Single-cycle op: on IDLE & start, gout ← decoded word. The FSM stays in IDLE, and `result` is unchanged.
- Multiply: on IDLE & start with a multiply decode:
  - gout ← 0010; load A←opa, B←opb, ACC←0, count←0; busy←1; go to MUL.
  - Each MUL cycle: if B[0], ACC←ACC+A (mod 2^WIDTH); then A←A<<1, B←B>>1, count←count+1.
  - After the WIDTH-th iteration: result←final ACC, busy←0, done←1, go to IDLE.
- Arithmetic: unsigned. Overflow above WIDTH bits is discarded silently.
- start in MUL is ignored; the in-flight operands are not disturbed.
- start in IDLE during a done-high cycle is accepted normally (back-to-back).
- Reset mid-multiply aborts the operation:
  - All registers clear immediately.
  - No done is produced.
  - result reads 0.

## Timing
- Reset values: gout=NOOP_CODE, result=0, busy=0, done=0, state IDLE, count=0.
- Single-cycle op: start sampled at edge N → gout valid and done=1 after edge N, for exactly one cycle.
- Multiply: start at edge N.
  - busy=1 after edge N.
  - Iterations occur on edges N+1…N+WIDTH.
  - After edge N+WIDTH: busy=0, done=1, result valid.
  - Latency is WIDTH cycles.
- gout holds its value until the next accepted start.
- result holds its value until the next multiply completes.
- done never asserts on two consecutive cycles without an intervening accepted start.

## Configuration
- ALUCONT_MULT_EN defined: the multiply path and MUL state are compiled in, as described above.
- ALUCONT_MULT_EN undefined:
  - R-type funct 1000 with aluop1=0 decodes to NOOP_CODE as a single-cycle op (done after 1 cycle).
  - The MUL state, accumulator and counter are absent.
  - busy is tied 0 and result is tied 0.

## Test plan
- Assert reset, then release → gout=1111, result=0, busy=0, done=0. Raise start with no clock edge and reset held → no change.
- aluop=000 start, then aluop=001, then aluop=011 on consecutive cycles → gout 0010, 0110, 1100, with done high each cycle after its start.
- aluop=100 with funct 1010, 0101, 0111, 0011 → gout 0111, 0001, 1001, 1101. aluop=110 with funct 1001 → 0100.
- WIDTH=8 with ALUCONT_MULT_EN, opa=7, opb=9:
  - done rises exactly 8 cycles after start; result=63; gout=0010 throughout.
  - Repeat with 200×3 → result=88.
  - A start pulse with different operands at cycle 3 → ignored, result still 88.
- WIDTH=8 multiply 15×15, with reset pulsed at cycle 4 → immediate reset values, no done. A following 2×3 → result=6 after 8 cycles.
- Build without ALUCONT_MULT_EN: aluop=100, funct=1000 → gout=1111, done after 1 cycle, busy stays 0.
